// File: rtl/window_scheduler_if.sv
// Control, strobe and status bundle between the window scheduler and its
// environment; the master side drives control and observes strobes/status.
interface window_scheduler_if;
    logic       en;
    logic       start;
    logic       flush;
    logic       sample_valid;
    logic       shift_1s;
    logic       shift_5s;
    logic       shift_30s;
    logic       shift_240s;
    logic       valid_1s;
    logic       valid_5s;
    logic       valid_30s;
    logic       valid_240s;
    logic       data_valid;
    logic       clr;
    logic [1:0] state;

    modport master (
        output en, start, flush, sample_valid,
        input  shift_1s, shift_5s, shift_30s, shift_240s,
        input  valid_1s, valid_5s, valid_30s, valid_240s, data_valid, clr, state
    );

    modport slave (
        input  en, start, flush, sample_valid,
        output shift_1s, shift_5s, shift_30s, shift_240s,
        output valid_1s, valid_5s, valid_30s, valid_240s, data_valid, clr, state
    );
endinterface

// File: rtl/window_scheduler.sv
// Divider cascade and fill tracker sequencing the 0.2 s / 1 s / 5 s / 30 s / 240 s
// sliding-window shift registers, with start/flush control.
module window_scheduler #(
    parameter int unsigned SPT       = 50,
    parameter int unsigned CHUNKS_1S = 5,
    parameter int unsigned N_5S      = 5,
    parameter int unsigned N_30S     = 6,
    parameter int unsigned N_240S    = 8,
    parameter int unsigned CNT_W     = 8
) (
    input logic              clk,
    input logic              rst,
    window_scheduler_if.slave bus
);
    typedef enum logic [1:0] {StIdle = 2'd0, StFill = 2'd1, StRun = 2'd2, StFlush = 2'd3} state_e;

    localparam logic [CNT_W-1:0] C0Max = CNT_W'(SPT - 1);
    localparam logic [CNT_W-1:0] C1Max = CNT_W'(CHUNKS_1S - 1);
    localparam logic [CNT_W-1:0] C2Max = CNT_W'(N_5S - 1);
    localparam logic [CNT_W-1:0] C3Max = CNT_W'(N_30S - 1);
    localparam logic [CNT_W-1:0] D1    = CNT_W'(CHUNKS_1S);
    localparam logic [CNT_W-1:0] D2    = CNT_W'(N_5S);
    localparam logic [CNT_W-1:0] D3    = CNT_W'(N_30S);
    localparam logic [CNT_W-1:0] D4    = CNT_W'(N_240S);
    localparam logic [CNT_W-1:0] One   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] c0_q, c0_d, c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
    logic [CNT_W-1:0] f1_q, f1_d, f2_q, f2_d, f3_q, f3_d, f4_q, f4_d;
    logic [3:0]       shift_q, shift_d;
    logic [3:0]       valid_q, valid_d;
    logic             counting, w0, w1, w2, w3;

    assign counting = (state_q == StFill || state_q == StRun) && !bus.en && bus.sample_valid;
    // Each wrap cascades only when every faster stage wraps on the same sample.
    assign w0 = counting && (c0_q == C0Max);
    assign w1 = w0 && (c1_q == C1Max);
    assign w2 = w1 && (c2_q == C2Max);
    assign w3 = w2 && (c3_q == C3Max);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            c0_q    <= '0;
            c1_q    <= '0;
            c2_q    <= '0;
            c3_q    <= '0;
            f1_q    <= '0;
            f2_q    <= '0;
            f3_q    <= '0;
            f4_q    <= '0;
            shift_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            c0_q    <= c0_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            c3_q    <= c3_d;
            f1_q    <= f1_d;
            f2_q    <= f2_d;
            f3_q    <= f3_d;
            f4_q    <= f4_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        c0_d    = c0_q;
        c1_d    = c1_q;
        c2_d    = c2_q;
        c3_d    = c3_q;
        f1_d    = f1_q;
        f2_d    = f2_q;
        f3_d    = f3_q;
        f4_d    = f4_q;
        shift_d = {w3, w2, w1, w0};
        valid_d = valid_q;

        if (counting) c0_d = w0 ? '0 : c0_q + One;
        if (w0) c1_d = w1 ? '0 : c1_q + One;
        if (w1) c2_d = w2 ? '0 : c2_q + One;
        if (w2) c3_d = w3 ? '0 : c3_q + One;

        // Fill counters saturate at depth; valid rises with the strobe that fills.
        if (w0 && f1_q != D1) begin
            f1_d = f1_q + One;
            if (f1_d == D1) valid_d[0] = 1'b1;
        end
        if (w1 && f2_q != D2) begin
            f2_d = f2_q + One;
            if (f2_d == D2) valid_d[1] = 1'b1;
        end
        if (w2 && f3_q != D3) begin
            f3_d = f3_q + One;
            if (f3_d == D3) valid_d[2] = 1'b1;
        end
        if (w3 && f4_q != D4) begin
            f4_d = f4_q + One;
            if (f4_d == D4) valid_d[3] = 1'b1;
        end

        unique case (state_q)
            StIdle:  if (bus.start) state_d = StFill;
            StFill:  if (valid_d[3]) state_d = StRun;
            StRun:   state_d = StRun;
            StFlush: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (bus.flush) begin
            state_d = StFlush;
            c0_d    = '0;
            c1_d    = '0;
            c2_d    = '0;
            c3_d    = '0;
            f1_d    = '0;
            f2_d    = '0;
            f3_d    = '0;
            f4_d    = '0;
            shift_d = '0;
            valid_d = '0;
        end
    end

    assign bus.shift_1s   = shift_q[0];
    assign bus.shift_5s   = shift_q[1];
    assign bus.shift_30s  = shift_q[2];
    assign bus.shift_240s = shift_q[3];
    assign bus.valid_1s   = valid_q[0];
    assign bus.valid_5s   = valid_q[1];
    assign bus.valid_30s  = valid_q[2];
    assign bus.valid_240s = valid_q[3];
    assign bus.data_valid = valid_q[3];
    assign bus.clr        = (state_q == StFlush);
    assign bus.state      = state_q;
endmodule

// File: tb/tb_window_scheduler.sv
// Scoreboard bench for window_scheduler: a sample-count reference model pushes the
// expected output vector per cycle, which is popped and compared after the clock edge.
module tb_window_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b0;
    window_scheduler_if bus ();

    window_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: n = samples counted since the last start.
    int         n   = 0;
    logic [1:0] mst = 2'd0;
    logic [11:0] exp_q[$];

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%03h expected=%03h (n=%0d, t=%0t)", tag, got, exp, n, $time);
        end
    endtask

    function automatic logic [11:0] observed();
        return {bus.state, bus.shift_1s, bus.shift_5s, bus.shift_30s, bus.shift_240s,
                bus.valid_1s, bus.valid_5s, bus.valid_30s, bus.valid_240s,
                bus.data_valid, bus.clr};
    endfunction

    task automatic drive(input string tag, input logic s, input logic f, input logic v,
                         input logic e);
        logic cnt;
        cnt = 1'b0;
        bus.start        = s;
        bus.flush        = f;
        bus.sample_valid = v;
        bus.en           = e;
        if (f) begin
            mst = 2'd3;
            n   = 0;
        end else begin
            case (mst)
                2'd0: if (s) mst = 2'd1;
                2'd3: mst = 2'd0;
                default: if (v && !e) begin
                    n++;
                    cnt = 1'b1;
                    if (mst == 2'd1 && n == 60000) mst = 2'd2;
                end
            endcase
        end
        exp_q.push_back({mst, cnt && (n % 50 == 0), cnt && (n % 250 == 0),
                         cnt && (n % 1250 == 0), cnt && (n % 7500 == 0),
                         n >= 250, n >= 1250, n >= 7500, n >= 60000, n >= 60000,
                         mst == 2'd3});
        @(posedge clk);
        #1;
        check(tag, observed(), exp_q.pop_front());
    endtask

    task automatic run_samples(input string tag, input int k, input int gap);
        for (int i = 0; i < k; i++) begin
            drive(tag, 1'b0, 1'b0, 1'b1, 1'b0);
            for (int j = 0; j < gap; j++) drive(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        bus.en           = 1'b0;
        bus.start        = 1'b0;
        bus.flush        = 1'b0;
        bus.sample_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", observed(), 12'h000);
        @(negedge clk);
        rst = 1'b1;
        drive("idle", 1'b0, 1'b0, 1'b1, 1'b0);
        drive("idle_sv_ignored", 1'b0, 1'b0, 1'b1, 1'b0);

        // Dense stream, with an enable pause mid-chunk
        drive("start", 1'b1, 1'b0, 1'b1, 1'b0);
        run_samples("dense_a", 125, 0);
        for (int i = 0; i < 20; i++) drive("en_pause", 1'b0, 1'b0, 1'b1, 1'b1);
        run_samples("dense_b", 60000 - 125, 0);
        check("reached_run", {30'd0, bus.state}, 32'd2);
        run_samples("run", 60, 0);

        // Asynchronous reset between edges
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst", observed(), 12'h000);
        n   = 0;
        mst = 2'd0;
        @(negedge clk);
        rst = 1'b1;

        // Sparse stream then dense to mid-FILL, then flush
        drive("restart", 1'b1, 1'b0, 1'b0, 1'b0);
        run_samples("sparse", 300, 2);
        run_samples("dense_c", 8000 - 300, 0);
        drive("flush_fill", 1'b0, 1'b1, 1'b1, 1'b0);
        check("flush_clr", {31'd0, bus.clr}, 32'd1);
        drive("after_flush", 1'b0, 1'b0, 1'b1, 1'b0);
        check("flush_idle", {30'd0, bus.state}, 32'd0);
        drive("restart2", 1'b1, 1'b0, 1'b1, 1'b0);
        run_samples("post_flush", 100, 0);

        // Flush and start together: flush wins
        drive("flush_end", 1'b0, 1'b1, 1'b0, 1'b0);
        drive("to_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        drive("flush_vs_start", 1'b1, 1'b1, 1'b1, 1'b0);
        check("flush_wins", {30'd0, bus.state}, 32'd3);
        for (int i = 0; i < 60; i++) drive("no_count", 1'b0, 1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
